// File: rtl/sort_pkg.sv
// Shared constants and FSM state encoding for the bubble-sort sequencer.
package sort_pkg;

  // Default configuration
  localparam int unsigned SortN     = 10;
  localparam int unsigned SortDataW = 16;
  localparam int unsigned SortAddrW = 4;
  localparam int unsigned SortCntW  = 8;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRdA  = 3'd1,
    StRdB  = 3'd2,
    StCmp  = 3'd3,
    StWrA  = 3'd4,
    StWrB  = 3'd5,
    StNext = 3'd6,
    StDone = 3'd7
  } sort_state_e;

endpackage

// File: rtl/sort_mem_mux.sv
// RAM port mux: the host drives the RAM when selected, otherwise the sequencer does.
module sort_mem_mux #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 16
) (
  input  logic              host_sel,
  input  logic              host_req,
  input  logic              host_wr,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  input  logic [ADDR_W-1:0] seq_addr,
  input  logic              seq_rd_en,
  input  logic              seq_wr_en,
  input  logic [DATA_W-1:0] seq_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wdata
);

  // Select the RAM owner; the host is only granted while selected
  always_comb begin
    host_gnt  = 1'b0;
    mem_addr  = seq_addr;
    mem_rd_en = seq_rd_en;
    mem_wr_en = seq_wr_en;
    mem_wdata = seq_wdata;
    if (host_sel) begin
      host_gnt  = host_req;
      mem_addr  = host_addr;
      mem_rd_en = host_req & ~host_wr;
      mem_wr_en = host_req & host_wr;
      mem_wdata = host_wdata;
    end
  end

endmodule

// File: rtl/sort_seq_ctrl.sv
// Bubble-sort sequencer over a shared 1R/1W synchronous RAM (1-cycle read latency).
// Optional feature: define SORT_EARLY_EXIT_EN to finish after the first pass with no swaps.
module sort_seq_ctrl
  import sort_pkg::*;
#(
  parameter int unsigned N      = SortN,
  parameter int unsigned DATA_W = SortDataW,
  parameter int unsigned ADDR_W = SortAddrW,
  parameter int unsigned CNT_W  = SortCntW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  swap_count,
  output logic [ADDR_W-1:0] pass_out,
  input  logic              host_req,
  input  logic              host_wr,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] LastPass = ADDR_W'(N - 2);
  localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CntOne   = CNT_W'(1);

  sort_state_e       state_q, state_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [ADDR_W-1:0] p_q, p_d;
  logic [CNT_W-1:0]  swap_q, swap_d;
  logic              flag_q, flag_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;

  logic              host_sel;
  logic [ADDR_W-1:0] seq_addr;
  logic              seq_rd_en;
  logic              seq_wr_en;
  logic [DATA_W-1:0] seq_wdata;
  logic              end_sort;

  // Sort is finished at the end of the last pass (or of a swap-free pass when enabled)
  always_comb begin
`ifdef SORT_EARLY_EXIT_EN
    end_sort = (p_q == LastPass) || !flag_q;
`else
    end_sort = (p_q == LastPass);
`endif
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      i_q     <= '0;
      p_q     <= '0;
      swap_q  <= '0;
      flag_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      p_q     <= p_d;
      swap_q  <= swap_d;
      flag_q  <= flag_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  // Next-state logic and sequencer RAM controls
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    p_d       = p_q;
    swap_d    = swap_q;
    flag_d    = flag_q;
    a_d       = a_q;
    b_d       = b_q;
    seq_addr  = '0;
    seq_rd_en = 1'b0;
    seq_wr_en = 1'b0;
    seq_wdata = '0;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRdA;
          i_d     = '0;
          p_d     = '0;
          swap_d  = '0;
          flag_d  = 1'b0;
        end
      end
      StRdA: begin
        seq_addr  = i_q;
        seq_rd_en = 1'b1;
        state_d   = StRdB;
      end
      StRdB: begin
        a_d       = mem_rdata;
        seq_addr  = i_q + AddrOne;
        seq_rd_en = 1'b1;
        state_d   = StCmp;
      end
      StCmp: begin
        b_d     = mem_rdata;
        // Strictly greater: equal items never swap, keeping the sort stable
        state_d = (a_q > mem_rdata) ? StWrA : StNext;
      end
      StWrA: begin
        seq_addr  = i_q;
        seq_wr_en = 1'b1;
        seq_wdata = b_q;
        state_d   = StWrB;
      end
      StWrB: begin
        seq_addr  = i_q + AddrOne;
        seq_wr_en = 1'b1;
        seq_wdata = a_q;
        flag_d    = 1'b1;
        if (swap_q != '1) swap_d = swap_q + CntOne;
        state_d   = StNext;
      end
      StNext: begin
        if (i_q < (LastPass - p_q)) begin
          i_d     = i_q + AddrOne;
          state_d = StRdA;
        end else if (end_sort) begin
          state_d = StDone;
        end else begin
          p_d     = p_q + AddrOne;
          i_d     = '0;
          flag_d  = 1'b0;
          state_d = StRdA;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Host owns the RAM only while idle and not being beaten by a start
  assign host_sel   = (state_q == StIdle) && !start;
  assign busy       = (state_q != StIdle);
  assign swap_count = swap_q;
  assign pass_out   = p_q;

  sort_mem_mux #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem_mux (
    .host_sel  (host_sel),
    .host_req  (host_req),
    .host_wr   (host_wr),
    .host_addr (host_addr),
    .host_wdata(host_wdata),
    .host_gnt  (host_gnt),
    .seq_addr  (seq_addr),
    .seq_rd_en (seq_rd_en),
    .seq_wr_en (seq_wr_en),
    .seq_wdata (seq_wdata),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata)
  );

endmodule
